// File: rtl/ysyx_22051013_lsu.sv
// rtl/ysyx_22051013_lsu.sv - load/store stage between EXU and WBU with req/ack data-memory bus
module ysyx_22051013_lsu #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    output logic          ls_ready,
    input  logic [AW-1:0] ex_res,
    input  logic [DW-1:0] store_data,
    input  logic [3:0]    mem_op,
    input  logic [4:0]    ex_rd,
    input  logic          ex_rd_wen,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          ls_valid,
    input  logic          wb_ready,
    output logic [DW-1:0] ls_res,
    output logic [4:0]    ls_rd,
    output logic          ls_rd_wen,
    output logic          ls_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM,
        S_HOLD
    } state_t;

    state_t        state;
    logic [3:0]    op_q;
    logic [2:0]    off_q;
    logic          rd_wen_q;

    logic          is_load;
    logic          is_store;
    logic [1:0]    sz;
    logic [2:0]    off;
    logic          misalign;
    logic [7:0]    wmask_n;
    logic          take;
    logic [DW-1:0] raw;
    logic [DW-1:0] ext;

    assign ls_ready = (state == S_IDLE) | ((state == S_HOLD) & wb_ready);
    assign take     = ex_valid & ls_ready;
    assign off      = ex_res[2:0];

    // sz: 0 byte, 1 half, 2 word, 3 double
    always_comb begin
        is_load  = (mem_op >= 4'd1) && (mem_op <= 4'd7);
        is_store = (mem_op >= 4'd8) && (mem_op <= 4'd11);
        case (mem_op)
            4'd1, 4'd5, 4'd8:  sz = 2'd0;
            4'd2, 4'd6, 4'd9:  sz = 2'd1;
            4'd3, 4'd7, 4'd10: sz = 2'd2;
            default:           sz = 2'd3;
        endcase
        case (sz)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = off[0];
            2'd2:    misalign = |off[1:0];
            default: misalign = |off;
        endcase
        case (sz)
            2'd0:    wmask_n = 8'h01 << off;
            2'd1:    wmask_n = 8'h03 << off;
            2'd2:    wmask_n = 8'h0F << off;
            default: wmask_n = 8'hFF;
        endcase
    end

    always_comb begin
        raw = mem_rdata >> {off_q, 3'b000};
        case (op_q)
            4'd1:    ext = {{(DW-8){raw[7]}}, raw[7:0]};
            4'd2:    ext = {{(DW-16){raw[15]}}, raw[15:0]};
            4'd3:    ext = {{(DW-32){raw[31]}}, raw[31:0]};
            4'd5:    ext = {{(DW-8){1'b0}}, raw[7:0]};
            4'd6:    ext = {{(DW-16){1'b0}}, raw[15:0]};
            4'd7:    ext = {{(DW-32){1'b0}}, raw[31:0]};
            default: ext = raw;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            ls_valid  <= 1'b0;
            ls_res    <= '0;
            ls_rd     <= '0;
            ls_rd_wen <= 1'b0;
            ls_err    <= 1'b0;
            op_q      <= '0;
            off_q     <= '0;
            rd_wen_q  <= 1'b0;
        end else begin
            case (state)
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        state     <= S_HOLD;
                        ls_valid  <= 1'b1;
                        ls_res    <= op_q[3] ? '0 : ext;
                        ls_rd_wen <= rd_wen_q;
                    end
                end
                S_HOLD: begin
                    if (wb_ready && !ex_valid) begin
                        state    <= S_IDLE;
                        ls_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
            // take only fires in IDLE/HOLD, so it never collides with the MEM branch
            if (take) begin
                ls_rd  <= ex_rd;
                ls_err <= 1'b0;
                if (!(is_load || is_store)) begin
                    state     <= S_HOLD;
                    ls_valid  <= 1'b1;
                    ls_res    <= ex_res;
                    ls_rd_wen <= ex_rd_wen;
                end else if (misalign) begin
                    state     <= S_HOLD;
                    ls_valid  <= 1'b1;
                    ls_err    <= 1'b1;
                    ls_res    <= '0;
                    ls_rd_wen <= 1'b0;
                end else begin
                    state     <= S_MEM;
                    ls_valid  <= 1'b0;
                    mem_req   <= 1'b1;
                    mem_we    <= is_store;
                    mem_addr  <= {ex_res[AW-1:3], 3'b000};
                    mem_wdata <= store_data << {off, 3'b000};
                    mem_wmask <= is_store ? wmask_n : 8'h00;
                    op_q      <= mem_op;
                    off_q     <= off;
                    rd_wen_q  <= is_load & ex_rd_wen;
                end
            end
        end
    end

endmodule
